// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// PcSequencer: control FSM that sequences the CPU program counter.
//
// Every instruction passes through FETCH (instruction memory handshake),
// then EXEC (datapath works until it signals done), and in the done cycle
// the next PC is chosen. Sequential flow, branches, jumps, calls, returns
// and halt are handled here. Calls and returns use a small internal
// return-address stack.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   run          level; leaves IDLE and starts fetching
//   pc_cur       current PC, read back from the PC register
//   new_pc       next PC, loaded by the PC register on every edge
//   imem_req     fetch request for address pc_cur (FETCH state)
//   imem_ack     fetch complete (only looked at in FETCH)
//   instr_valid  instruction present, datapath may execute (EXEC state)
//   exec_done    datapath finished; control flags below are sampled now
//   halt/ret/call/jmp/br_taken  control flags, in falling priority
//   jmp_target   target of jmp and call
//   br_target    target of a taken branch
//   halted       FSM sits in HALT
//   stack_err    sticky overflow/underflow flag
//   state        FSM state code for debug
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            run,
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] new_pc,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            halt,
    input  logic            ret,
    input  logic            call,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            halted,
    output logic            stack_err,
    output logic [2:0]      state
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        FETCH = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic            req_q, valid_q, halted_q;
    logic            push;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    // Sequential successor; doubles as the return address pushed by a call,
    // so both wrap from the top of the address space back to zero.
    assign pc_inc = pc_cur + PC_W'(1);

    // Next-state and next-PC selection. The PC register loads new_pc on
    // every edge, so holding means echoing pc_cur back. Only the exec_done
    // cycle of EXEC ever moves the PC; the flags are honoured strictly in
    // priority order and only the highest one takes effect. Stack faults
    // hold the PC and park the machine in HALT.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        err_d   = err_q;
        new_pc  = pc_cur;
        push    = 1'b0;
        case (state_q)
            BOOT:  state_d = IDLE;
            IDLE:  if (run) state_d = FETCH;
            FETCH: if (imem_ack) state_d = EXEC;
            EXEC: begin
                if (exec_done) begin
                    state_d = FETCH;
                    if (halt) begin
                        state_d = HALT;
                    end else if (ret) begin
                        if (sp_q == '0) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            new_pc = stack_q[IDX_W'(sp_q - 1'b1)];
                            sp_d   = sp_q - 1'b1;
                        end
                    end else if (call) begin
                        if (sp_q == SP_FULL) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            push   = 1'b1;
                            sp_d   = sp_q + 1'b1;
                            new_pc = jmp_target;
                        end
                    end else if (jmp) begin
                        new_pc = jmp_target;
                    end else if (br_taken) begin
                        new_pc = br_target;
                    end else begin
                        new_pc = pc_inc;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // State, stack pointer, sticky error and the decoded status outputs.
    // The status outputs are flops loaded from the next state, so they are
    // glitch-free with no combinational path from the inputs, and the
    // asynchronous reset drops them immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= BOOT;
            sp_q     <= '0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            req_q    <= (state_d == FETCH);
            valid_q  <= (state_d == EXEC);
            halted_q <= (state_d == HALT);
        end
    end

    // Return-address storage. Contents are don't-care after reset because
    // only entries below the stack pointer are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            stack_q[IDX_W'(sp_q)] <= pc_inc;
        end
    end

    assign imem_req    = req_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign stack_err   = err_q;
    assign state       = state_q;

endmodule
